// File: rtl/program_sequencer.sv
// Instruction store and run sequencer for the 8-bit core: streams a program into RAM,
// holds the core in reset, then serves mem[pc] and stops on end, self-loop or timeout.
module program_sequencer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AW           = 4,
  parameter int unsigned RESET_CYCLES = 2,
  parameter logic [7:0]  MAX_CYCLES   = 8'd255,
  parameter logic [7:0]  FILL         = 8'h00
) (
  input  logic          origclk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          start,
  input  logic [7:0]    pc,
  output logic [7:0]    instruction,
  output logic          core_reset,
  output logic          running,
  output logic          done,
  output logic [1:0]    status,
  output logic [AW:0]   prog_len,
  output logic [7:0]    cycle_count,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READY, S_CRST, S_RUN, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE, ST_END, ST_LOOP, ST_TIMEOUT
  } status_t;

  state_t        state_q, state_d;
  status_t       status_q, status_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic [7:0]    cycle_count_q, cycle_count_d;
  logic          error_q, error_d;
  logic [7:0]    pc_prev_q, pc_prev_d;
  logic          pc_prev_vld_q, pc_prev_vld_d;
  logic [7:0]    crst_cnt_q, crst_cnt_d;
  logic [7:0]    mem_q [DEPTH];

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic          beat;
  logic          pc_in_prog;
  logic [8:0]    cycle_next;

  always_comb begin
    load_ready  = !(state_q inside {S_CRST, S_RUN});
    core_reset  = state_q inside {S_IDLE, S_LOAD, S_READY, S_CRST};
    running     = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    pc_in_prog  = {1'b0, pc} < 9'(prog_len_q);
    instruction = '0;
    if (state_q inside {S_RUN, S_DONE})
      instruction = pc_in_prog ? mem_q[pc[AW-1:0]] : FILL;
  end

  assign status      = status_q;
  assign prog_len    = prog_len_q;
  assign cycle_count = cycle_count_q;
  assign error       = error_q;

  always_comb begin
    state_d       = state_q;
    status_d      = status_q;
    wr_ptr_d      = wr_ptr_q;
    prog_len_d    = prog_len_q;
    cycle_count_d = cycle_count_q;
    error_d       = error_q;
    pc_prev_d     = pc_prev_q;
    pc_prev_vld_d = pc_prev_vld_q;
    crst_cnt_d    = crst_cnt_q;
    mem_we        = 1'b0;
    mem_waddr     = wr_ptr_q;
    beat          = load_valid & load_ready;
    cycle_next    = {1'b0, cycle_count_q} + 9'd1;

    if (beat) begin
      mem_we = 1'b1;
      if (state_q == S_LOAD) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        prog_len_d = prog_len_q + (AW+1)'(1);
        if (load_last) begin
          state_d = S_READY;
        end else if (wr_ptr_q == AW'(DEPTH-1)) begin
          state_d = S_READY;
          error_d = 1'b1;
        end
      end else begin
        // Any beat outside LOAD discards the old program and restarts at address 0.
        mem_waddr  = '0;
        wr_ptr_d   = AW'(1);
        prog_len_d = (AW+1)'(1);
        error_d    = 1'b0;
        state_d    = load_last ? S_READY : S_LOAD;
      end
    end else begin
      case (state_q)
        S_READY, S_DONE: begin
          if (start) begin
            state_d       = S_CRST;
            cycle_count_d = '0;
            status_d      = ST_NONE;
            crst_cnt_d    = '0;
          end
        end
        S_CRST: begin
          if (crst_cnt_q == 8'(RESET_CYCLES-1)) begin
            state_d       = S_RUN;
            pc_prev_vld_d = 1'b0;
          end else begin
            crst_cnt_d = crst_cnt_q + 8'd1;
          end
        end
        S_RUN: begin
          cycle_count_d = cycle_next[8] ? 8'hFF : cycle_next[7:0];
          pc_prev_d     = pc;
          pc_prev_vld_d = 1'b1;
          if (!pc_in_prog) begin
            state_d  = S_DONE;
            status_d = ST_END;
          end else if (pc_prev_vld_q && (pc == pc_prev_q)) begin
            state_d  = S_DONE;
            status_d = ST_LOOP;
          end else if (cycle_next == {1'b0, MAX_CYCLES}) begin
            state_d  = S_DONE;
            status_d = ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge origclk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      status_q      <= ST_NONE;
      wr_ptr_q      <= '0;
      prog_len_q    <= '0;
      cycle_count_q <= '0;
      error_q       <= 1'b0;
      pc_prev_q     <= '0;
      pc_prev_vld_q <= 1'b0;
      crst_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      status_q      <= status_d;
      wr_ptr_q      <= wr_ptr_d;
      prog_len_q    <= prog_len_d;
      cycle_count_q <= cycle_count_d;
      error_q       <= error_d;
      pc_prev_q     <= pc_prev_d;
      pc_prev_vld_q <= pc_prev_vld_d;
      crst_cnt_q    <= crst_cnt_d;
    end
  end

  always_ff @(posedge origclk) begin
    if (mem_we && !reset)
      mem_q[mem_waddr] <= load_data;
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: two instances (default and short-timeout) share stimulus
// and are checked every cycle against a behavioural model, plus directed literal checks.
module tb_program_sequencer;

  localparam int DEPTH = 16;
  localparam logic [7:0] FILL = 8'h00;
  localparam int P_IDLE = 0, P_LOAD = 1, P_READY = 2, P_CRST = 3, P_RUN = 4, P_DONE = 5;

  logic       origclk;
  logic       reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       start;
  logic [7:0] pc;

  logic       lr_a, cr_a, run_a, dn_a, er_a;
  logic [7:0] ins_a, cc_a;
  logic [1:0] st_a;
  logic [4:0] pl_a;
  logic       lr_b, cr_b, run_b, dn_b, er_b;
  logic [7:0] ins_b, cc_b;
  logic [1:0] st_b;
  logic [4:0] pl_b;

  int n_cmp = 0;
  int n_bad = 0;

  program_sequencer #(
    .DEPTH(16), .AW(4), .RESET_CYCLES(2), .MAX_CYCLES(8'd255), .FILL(8'h00)
  ) u_a (
    .origclk(origclk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(lr_a), .start(start), .pc(pc),
    .instruction(ins_a), .core_reset(cr_a), .running(run_a), .done(dn_a),
    .status(st_a), .prog_len(pl_a), .cycle_count(cc_a), .error(er_a)
  );

  program_sequencer #(
    .DEPTH(16), .AW(4), .RESET_CYCLES(3), .MAX_CYCLES(8'd4), .FILL(8'h00)
  ) u_b (
    .origclk(origclk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(lr_b), .start(start), .pc(pc),
    .instruction(ins_b), .core_reset(cr_b), .running(run_b), .done(dn_b),
    .status(st_b), .prog_len(pl_b), .cycle_count(cc_b), .error(er_b)
  );

  initial origclk = 1'b0;
  always #5 origclk = ~origclk;

  // Behavioural model: program as a word list plus a run summary per instance.
  int         m_phase [2];
  logic [7:0] m_prog  [2][16];
  int         m_n     [2];
  int         m_err   [2];
  int         m_crst  [2];
  int         m_cyc   [2];
  int         m_st    [2];
  int         m_last  [2];
  bit         m_live = 1'b0;

  function automatic int rc(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic int mc(input int k);
    return (k == 0) ? 255 : 4;
  endfunction

  function automatic bit exp_ready(input int k);
    return !(m_phase[k] == P_CRST || m_phase[k] == P_RUN);
  endfunction

  function automatic logic [7:0] exp_instr(input int k);
    if (m_phase[k] != P_RUN && m_phase[k] != P_DONE) return 8'h00;
    if (int'(pc) < m_n[k]) return m_prog[k][pc[3:0]];
    return FILL;
  endfunction

  task automatic model_step(input int k);
    int p;
    p = int'(pc);
    if (reset) begin
      m_phase[k] = P_IDLE; m_n[k] = 0; m_err[k] = 0; m_cyc[k] = 0; m_st[k] = 0; m_last[k] = -1;
    end else if (load_valid && exp_ready(k)) begin
      if (m_phase[k] == P_LOAD) begin
        m_prog[k][m_n[k]] = load_data;
        m_n[k]++;
        if (load_last) m_phase[k] = P_READY;
        else if (m_n[k] == DEPTH) begin m_phase[k] = P_READY; m_err[k] = 1; end
      end else begin
        m_prog[k][0] = load_data;
        m_n[k] = 1;
        m_err[k] = 0;
        m_phase[k] = load_last ? P_READY : P_LOAD;
      end
    end else if (start && (m_phase[k] == P_READY || m_phase[k] == P_DONE)) begin
      m_phase[k] = P_CRST; m_crst[k] = rc(k); m_cyc[k] = 0; m_st[k] = 0; m_last[k] = -1;
    end else if (m_phase[k] == P_CRST) begin
      m_crst[k]--;
      if (m_crst[k] == 0) m_phase[k] = P_RUN;
    end else if (m_phase[k] == P_RUN) begin
      m_cyc[k] = (m_cyc[k] < 255) ? m_cyc[k] + 1 : 255;
      if (p >= m_n[k])              begin m_phase[k] = P_DONE; m_st[k] = 1; end
      else if (p == m_last[k])      begin m_phase[k] = P_DONE; m_st[k] = 2; end
      else if (m_cyc[k] == mc(k))   begin m_phase[k] = P_DONE; m_st[k] = 3; end
      m_last[k] = p;
    end
  endtask

  always @(posedge origclk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    if (reset) m_live = 1'b1;
  end

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %0h want %0h at %0t", k, name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input logic lr, input logic [7:0] ins, input logic cr,
                           input logic rn, input logic dn, input logic [1:0] st,
                           input logic [4:0] pl, input logic [7:0] cc, input logic er);
    chk(k, "load_ready",  32'(lr),  32'(exp_ready(k)));
    chk(k, "instruction", 32'(ins), 32'(exp_instr(k)));
    chk(k, "core_reset",  32'(cr),  32'(m_phase[k] <= P_CRST));
    chk(k, "running",     32'(rn),  32'(m_phase[k] == P_RUN));
    chk(k, "done",        32'(dn),  32'(m_phase[k] == P_DONE));
    chk(k, "status",      32'(st),  32'(m_st[k]));
    chk(k, "prog_len",    32'(pl),  32'(m_n[k]));
    chk(k, "cycle_count", 32'(cc),  32'(m_cyc[k]));
    chk(k, "error",       32'(er),  32'(m_err[k]));
  endtask

  always @(negedge origclk) begin
    if (m_live) begin
      check_dut(0, lr_a, ins_a, cr_a, run_a, dn_a, st_a, pl_a, cc_a, er_a);
      check_dut(1, lr_b, ins_b, cr_b, run_b, dn_b, st_b, pl_b, cc_b, er_b);
    end
  end

  task automatic tick;
    @(posedge origclk);
    #1;
  endtask

  task automatic load_word(input logic [7:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick;
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic kick;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prog5 [5];
    prog5 = '{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3};
    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0; start = 1'b0; pc = '0;
    tick; tick; #2;
    chk(0, "lit reset core_reset", 32'(cr_a), 32'd1);
    chk(0, "lit reset running",    32'(run_a), 32'd0);
    chk(0, "lit reset prog_len",   32'(pl_a), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) load_word(prog5[i], i == 4);
    #2;
    chk(0, "lit load prog_len",   32'(pl_a), 32'd5);
    chk(0, "lit load error",      32'(er_a), 32'd0);
    chk(0, "lit load core_reset", 32'(cr_a), 32'd1);

    kick; #2;
    chk(0, "lit crst1 core_reset", 32'(cr_a), 32'd1);
    tick; #2;
    chk(0, "lit crst2 core_reset", 32'(cr_a), 32'd1);
    chk(0, "lit crst2 running",    32'(run_a), 32'd0);
    tick; #2;
    chk(0, "lit run running", 32'(run_a), 32'd1);
    pc = 8'd0; #2; chk(0, "lit instr pc0", 32'(ins_a), 32'h44); tick;
    pc = 8'd1; #2; chk(0, "lit instr pc1", 32'(ins_a), 32'h49); tick;
    pc = 8'd2; #2; chk(0, "lit instr pc2", 32'(ins_a), 32'h18); tick;
    pc = 8'd3; tick;
    pc = 8'd3; tick; #2;
    chk(0, "lit loop done",        32'(dn_a), 32'd1);
    chk(0, "lit loop status",      32'(st_a), 32'd2);
    chk(0, "lit loop cycle_count", 32'(cc_a), 32'd5);
    chk(0, "lit loop instr",       32'(ins_a), 32'h89);

    kick; tick; tick;
    for (int i = 0; i < 5; i++) begin pc = 8'(i); tick; end
    pc = 8'd5; #2;
    chk(0, "lit fill running", 32'(ins_a), 32'h00);
    tick; #2;
    chk(0, "lit end status", 32'(st_a), 32'd1);
    chk(0, "lit end cycle_count", 32'(cc_a), 32'd6);

    for (int i = 0; i < 16; i++) load_word(8'($urandom), 1'b0);
    #2;
    chk(0, "lit overflow prog_len", 32'(pl_a), 32'd16);
    chk(0, "lit overflow error",    32'(er_a), 32'd1);
    load_word(8'hA5, 1'b0); #2;
    chk(0, "lit restart prog_len", 32'(pl_a), 32'd1);
    chk(0, "lit restart error",    32'(er_a), 32'd0);

    reset = 1'b1; tick; reset = 1'b0;
    for (int i = 0; i < 8; i++) load_word(8'(i * 3 + 1), i == 7);
    kick; tick; tick;
    for (int i = 0; i < 9; i++) begin pc = (i < 8) ? 8'(i) : 8'd7; tick; end
    #2;
    chk(0, "lit loop9 status",      32'(st_a), 32'd2);
    chk(0, "lit loop9 cycle_count", 32'(cc_a), 32'd9);
    chk(1, "lit timeout4 status",   32'(st_b), 32'd3);
    chk(1, "lit timeout4 cycle_count", 32'(cc_b), 32'd4);

    kick; tick; tick;
    for (int i = 0; i < 255; i++) begin pc = 8'(i % 2); tick; end
    #2;
    chk(0, "lit timeout255 status",      32'(st_a), 32'd3);
    chk(0, "lit timeout255 cycle_count", 32'(cc_a), 32'd255);

    kick; tick; tick;
    pc = 8'd0; tick; pc = 8'd1; tick;
    reset = 1'b1; tick; reset = 1'b0; #2;
    chk(0, "lit midrun running",    32'(run_a), 32'd0);
    chk(0, "lit midrun core_reset", 32'(cr_a), 32'd1);
    chk(0, "lit midrun prog_len",   32'(pl_a), 32'd0);
    chk(0, "lit midrun status",     32'(st_a), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      reset      = ($urandom_range(0, 299) == 0);
      start      = ($urandom_range(0, 9) == 0);
      load_valid = ($urandom_range(0, 3) == 0);
      load_data  = 8'($urandom);
      load_last  = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0, 1:    pc = pc + 8'd1;
        2:       pc = pc;
        default: pc = 8'($urandom_range(0, 20));
      endcase
      tick;
    end
    reset = 1'b0; start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    tick; tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
